// File: rtl/mem_ctrl_pkg.sv
// Shared opcode map, FSM state type and access decoder
// for the SPARC-style byte memory controller.
package mem_ctrl_pkg;

    localparam logic [5:0] OP_LOAD_W   = 6'b000000;
    localparam logic [5:0] OP_LOAD_UB  = 6'b000001;
    localparam logic [5:0] OP_LOAD_UHW = 6'b000010;
    localparam logic [5:0] OP_LOAD_SB  = 6'b001001;
    localparam logic [5:0] OP_LOAD_SHW = 6'b001010;
    localparam logic [5:0] OP_STORE_W  = 6'b000100;
    localparam logic [5:0] OP_STORE_B  = 6'b000101;
    localparam logic [5:0] OP_STORE_HW = 6'b000110;
    localparam logic [5:0] OP_LDSTUB   = 6'b001101;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_e;

    typedef enum logic [1:0] {SZ_B, SZ_HW, SZ_W} size_e;

    typedef struct packed {
        size_e size;
        logic  sgn;
        logic  is_store;
        logic  is_ldstub;
        logic  legal;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [5:0] op);
        op_info_t i;
        i = '{size: SZ_W, sgn: 1'b0, is_store: 1'b0,
              is_ldstub: 1'b0, legal: 1'b1};
        case (op)
            OP_LOAD_W:   i.size = SZ_W;
            OP_LOAD_UB:  i.size = SZ_B;
            OP_LOAD_UHW: i.size = SZ_HW;
            OP_LOAD_SB:  begin i.size = SZ_B;  i.sgn = 1'b1; end
            OP_LOAD_SHW: begin i.size = SZ_HW; i.sgn = 1'b1; end
            OP_STORE_W:  begin i.size = SZ_W;  i.is_store = 1'b1; end
            OP_STORE_B:  begin i.size = SZ_B;  i.is_store = 1'b1; end
            OP_STORE_HW: begin i.size = SZ_HW; i.is_store = 1'b1; end
            OP_LDSTUB:   begin i.size = SZ_B;  i.is_ldstub = 1'b1; end
            default:     i.legal = 1'b0;
        endcase
        return i;
    endfunction

    // Returns {illegal, misaligned}; misaligned only for legal opcodes.
    function automatic logic [1:0] op_fault(input logic [5:0] op,
                                            input logic [1:0] lo);
        op_info_t i;
        logic     mis;
        i   = decode_op(op);
        mis = (i.size == SZ_W && lo != 2'b00) ||
              (i.size == SZ_HW && lo[0]);
        return {!i.legal, i.legal && mis};
    endfunction

endpackage

// File: rtl/mem_ctrl_sparc_byte_ram.sv
// Byte-organised storage with one word-aligned 4-lane port;
// lane 0 (bits 31:24) is the lowest byte address.
module byte_ram #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [3:0]            we,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [7:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;

    assign a0 = addr & ~ADDR_WIDTH'(3);
    assign a1 = a0 | ADDR_WIDTH'(1);
    assign a2 = a0 | ADDR_WIDTH'(2);
    assign a3 = a0 | ADDR_WIDTH'(3);

    always_ff @(posedge clk) begin
        if (we[3]) mem[a0] <= wdata[31:24];
        if (we[2]) mem[a1] <= wdata[23:16];
        if (we[1]) mem[a2] <= wdata[15:8];
        if (we[0]) mem[a3] <= wdata[7:0];
    end

    assign rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};

endmodule

// File: rtl/mem_ctrl_sparc.sv
// MOV/MFC memory controller: request latch, wait states,
// big-endian lane steering, load extension and fault reporting.
module mem_ctrl_sparc
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [5:0]            opcode,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    output logic                  mfc,
    output logic                  busy,
    output logic                  misaligned,
    output logic                  illegal_op
);

    localparam logic [3:0] WS_INIT =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_e                state_q, state_d;
    logic [5:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           dout_q, dout_d;
    logic                  mfc_q, mfc_d;
    logic                  mis_q, mis_d;
    logic                  ill_q, ill_d;

    op_info_t    cur;
    logic [1:0]  req_fault, cur_fault;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata, ram_rdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    assign cur       = decode_op(op_q);
    assign req_fault = op_fault(opcode, address[1:0]);
    assign cur_fault = op_fault(op_q, addr_q[1:0]);

    byte_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .addr  (addr_q),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Replicate store data across lanes; the enable mask picks the bytes.
    always_comb begin
        ram_wdata = data_q;
        ram_we    = 4'b1111;
        case (cur.size)
            SZ_B: begin
                ram_we    = 4'b1000 >> addr_q[1:0];
                ram_wdata = {4{data_q[7:0]}};
            end
            SZ_HW: begin
                ram_we    = 4'b1100 >> addr_q[1:0];
                ram_wdata = {2{data_q[15:0]}};
            end
            default: ;
        endcase
        if (cur.is_ldstub)
            ram_wdata = '1;
        if (state_q != ACCESS || !cur.legal ||
            !(cur.is_store || cur.is_ldstub))
            ram_we = 4'b0000;
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = ram_rdata[31:24];
            2'd1:    ld_byte = ram_rdata[23:16];
            2'd2:    ld_byte = ram_rdata[15:8];
            default: ld_byte = ram_rdata[7:0];
        endcase
        ld_half = addr_q[1] ? ram_rdata[15:0] : ram_rdata[31:16];
        case (cur.size)
            SZ_B:    ld_val = {{24{cur.sgn & ld_byte[7]}}, ld_byte};
            SZ_HW:   ld_val = {{16{cur.sgn & ld_half[15]}}, ld_half};
            default: ld_val = ram_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        mfc_d   = mfc_q;
        mis_d   = mis_q;
        ill_d   = ill_q;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    op_d   = opcode;
                    addr_d = address;
                    data_d = data_in;
                    cnt_d  = WS_INIT;
                    if (req_fault != 2'b00)
                        state_d = DONE;
                    else if (WAIT_STATES == 0)
                        state_d = ACCESS;
                    else
                        state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0)
                    state_d = ACCESS;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            ACCESS: begin
                state_d = DONE;
                mfc_d   = 1'b1;
                if (!cur.is_store)
                    dout_d = ld_val;
            end
            DONE: begin
                // Faulted requests raise mfc one edge after acceptance.
                mfc_d = 1'b1;
                ill_d = cur_fault[1];
                mis_d = cur_fault[0];
                if (mfc_q && !enable) begin
                    state_d = IDLE;
                    mfc_d   = 1'b0;
                    ill_d   = 1'b0;
                    mis_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            mfc_q   <= 1'b0;
            mis_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            mfc_q   <= mfc_d;
            mis_q   <= mis_d;
            ill_q   <= ill_d;
        end
    end

    assign data_out   = dout_q;
    assign mfc        = mfc_q;
    assign busy       = (state_q != IDLE);
    assign misaligned = mis_q;
    assign illegal_op = ill_q;

endmodule

// File: tb/tb_mem_ctrl_sparc.sv
// Directed bench for mem_ctrl_sparc: default instance plus a
// zero-wait-state instance sharing clock, reset and request bus.
module tb_mem_ctrl_sparc;

    localparam logic [5:0] LW   = 6'b000000;
    localparam logic [5:0] LUB  = 6'b000001;
    localparam logic [5:0] LUHW = 6'b000010;
    localparam logic [5:0] LSB  = 6'b001001;
    localparam logic [5:0] LSHW = 6'b001010;
    localparam logic [5:0] SW   = 6'b000100;
    localparam logic [5:0] SB   = 6'b000101;
    localparam logic [5:0] SHW  = 6'b000110;
    localparam logic [5:0] LDSU = 6'b001101;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en, en0;
    logic [5:0]  opcode;
    logic [7:0]  address;
    logic [31:0] data_in;
    logic [31:0] dout, dout0;
    logic        mfc, mfc0, busy, busy0;
    logic        mis_o, mis0, ill_o, ill0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_ctrl_sparc dut (
        .clk(clk), .reset_n(reset_n), .enable(en), .opcode(opcode),
        .address(address), .data_in(data_in), .data_out(dout),
        .mfc(mfc), .busy(busy), .misaligned(mis_o), .illegal_op(ill_o)
    );

    mem_ctrl_sparc #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .enable(en0), .opcode(opcode),
        .address(address), .data_in(data_in), .data_out(dout0),
        .mfc(mfc0), .busy(busy0), .misaligned(mis0), .illegal_op(ill0)
    );

    // One full handshake; cyc counts edges after the request edge E0.
    task automatic req(input bit ws0, input logic [5:0] op,
                       input logic [7:0] a, input logic [31:0] d,
                       output int cyc, output logic [31:0] q,
                       output logic m, output logic il);
        logic done;
        @(negedge clk);
        opcode = op; address = a; data_in = d;
        if (ws0) en0 = 1'b1; else en = 1'b1;
        @(posedge clk);
        #2;
        opcode = 6'($urandom); address = 8'($urandom);
        data_in = $urandom;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            done = ws0 ? mfc0 : mfc;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL req_timeout op=%b addr=%0d: mfc=0 after %0d, want 1",
                     op, a, cyc);
        end
        q  = ws0 ? dout0 : dout;
        m  = ws0 ? mis0 : mis_o;
        il = ws0 ? ill0 : ill_o;
        @(negedge clk);
        en = 1'b0; en0 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++;
        if (dout !== 32'h0) begin errors++;
            $display("FAIL reset_dout got %h want 0", dout); end
        checks++;
        if ({mfc, busy, mis_o, ill_o} !== 4'b0) begin errors++;
            $display("FAIL reset_flags got %b want 0000",
                     {mfc, busy, mis_o, ill_o}); end
        checks++;
        if ({mfc0, busy0, dout0} !== 34'h0) begin errors++;
            $display("FAIL reset_ws0 got %b/%b/%h want 0",
                     mfc0, busy0, dout0); end
    endtask

    task automatic test_word;
        int c; logic [31:0] q; logic m, il;
        req(0, SW, 8'd0, 32'd234512, c, q, m, il);
        checks++;
        if (c !== 3) begin errors++;
            $display("FAIL sw_latency got %0d want 3", c); end
        checks++;
        if (q !== 32'h0) begin errors++;
            $display("FAIL sw_dout_unchanged got %h want 0", q); end
        req(0, LW, 8'd0, 32'h0, c, q, m, il);
        checks++;
        if (q !== 32'h00039410 || c !== 3) begin errors++;
            $display("FAIL lw0 got %h/%0d want 00039410/3", q, c); end
        req(0, LUB, 8'd1, 32'h0, c, q, m, il);
        checks++;
        if (q !== 32'h00000003) begin errors++;
            $display("FAIL lub1 got %h want 00000003", q); end
        req(0, LUB, 8'd3, 32'h0, c, q, m, il);
        checks++;
        if (q !== 32'h00000010) begin errors++;
            $display("FAIL lub3 got %h want 00000010", q); end
    endtask

    task automatic test_byte;
        int c; logic [31:0] q; logic m, il;
        req(0, SW, 8'd4, 32'h11223344, c, q, m, il);
        req(0, SB, 8'd4, 32'hFFFFFFFB, c, q, m, il);
        req(0, LW, 8'd4, 32'h0, c, q, m, il);
        checks++;
        if (q !== 32'hFB223344) begin errors++;
            $display("FAIL sb_word got %h want fb223344", q); end
        req(0, LUB, 8'd4, 32'h0, c, q, m, il);
        checks++;
        if (q !== 32'h000000FB) begin errors++;
            $display("FAIL lub4 got %h want 000000fb", q); end
        req(0, LSB, 8'd4, 32'h0, c, q, m, il);
        checks++;
        if (q !== 32'hFFFFFFFB) begin errors++;
            $display("FAIL lsb4 got %h want fffffffb", q); end
    endtask

    task automatic test_half;
        int c; logic [31:0] q; logic m, il;
        req(0, SW, 8'd8, 32'hAABBCCDD, c, q, m, il);
        req(0, SHW, 8'd8, 32'hFFFFF6CC, c, q, m, il);
        req(0, LW, 8'd8, 32'h0, c, q, m, il);
        checks++;
        if (q !== 32'hF6CCCCDD) begin errors++;
            $display("FAIL shw_word got %h want f6ccccdd", q); end
        req(0, LUHW, 8'd8, 32'h0, c, q, m, il);
        checks++;
        if (q !== 32'h0000F6CC) begin errors++;
            $display("FAIL luhw8 got %h want 0000f6cc", q); end
        req(0, LSHW, 8'd8, 32'h0, c, q, m, il);
        checks++;
        if (q !== 32'hFFFFF6CC) begin errors++;
            $display("FAIL lshw8 got %h want fffff6cc", q); end
        req(0, LSHW, 8'd10, 32'h0, c, q, m, il);
        checks++;
        if (q !== 32'hFFFFCCDD) begin errors++;
            $display("FAIL lshw10 got %h want ffffccdd", q); end
        req(0, LSB, 8'd11, 32'h0, c, q, m, il);
        checks++;
        if (q !== 32'hFFFFFFDD) begin errors++;
            $display("FAIL lsb11 got %h want ffffffdd", q); end
    endtask

    task automatic test_faults;
        int c; logic [31:0] q; logic m, il;
        req(0, LW, 8'd2, 32'h0, c, q, m, il);
        checks++;
        if ({m, il} !== 2'b10 || c !== 1) begin errors++;
            $display("FAIL lw_mis got m=%b i=%b c=%0d want 1/0/1", m, il, c); end
        checks++;
        if (q !== 32'hFFFFFFDD) begin errors++;
            $display("FAIL lw_mis_dout got %h want ffffffdd", q); end
        checks++;
        if ({mfc, mis_o, busy} !== 3'b000) begin errors++;
            $display("FAIL fault_clear got %b want 000", {mfc, mis_o, busy}); end
        req(0, SHW, 8'd9, 32'h00001234, c, q, m, il);
        checks++;
        if ({m, il} !== 2'b10 || c !== 1) begin errors++;
            $display("FAIL shw_mis got m=%b i=%b c=%0d want 1/0/1", m, il, c); end
        req(0, 6'b111111, 8'd8, 32'h0, c, q, m, il);
        checks++;
        if ({m, il} !== 2'b01 || c !== 1) begin errors++;
            $display("FAIL illegal got m=%b i=%b c=%0d want 0/1/1", m, il, c); end
        req(0, LW, 8'd8, 32'h0, c, q, m, il);
        checks++;
        if (q !== 32'hF6CCCCDD) begin errors++;
            $display("FAIL fault_nowrite got %h want f6ccccdd", q); end
    endtask

    task automatic test_ldstub;
        int c; logic [31:0] q; logic m, il;
        req(0, LDSU, 8'd4, 32'h0, c, q, m, il);
        checks++;
        if (q !== 32'h000000FB) begin errors++;
            $display("FAIL ldstub_old got %h want 000000fb", q); end
        req(0, LUB, 8'd4, 32'h0, c, q, m, il);
        checks++;
        if (q !== 32'h000000FF) begin errors++;
            $display("FAIL ldstub_set got %h want 000000ff", q); end
        req(0, LW, 8'd4, 32'h0, c, q, m, il);
        checks++;
        if (q !== 32'hFF223344) begin errors++;
            $display("FAIL ldstub_word got %h want ff223344", q); end
    endtask

    task automatic test_hold;
        int c; logic [31:0] q; logic m, il;
        int n;
        @(negedge clk);
        opcode = LW; address = 8'd0; en = 1'b1;
        @(posedge clk);
        #2;
        opcode = SW; data_in = 32'h0BADF00D; address = 8'd0;
        n = 0;
        while (!mfc && n < 20) begin @(posedge clk); #1; n++; end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({mfc, busy} !== 2'b11 || dout !== 32'h00039410) begin
                errors++;
                $display("FAIL hold_%0d got mfc=%b busy=%b d=%h want 1/1/00039410",
                         k, mfc, busy, dout);
            end
        end
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({mfc, busy} !== 2'b00 || dout !== 32'h00039410) begin errors++;
            $display("FAIL hold_release got %b%b d=%h want 00/00039410",
                     mfc, busy, dout); end
        req(0, LW, 8'd0, 32'h0, c, q, m, il);
        checks++;
        if (q !== 32'h00039410) begin errors++;
            $display("FAIL hold_nowrite got %h want 00039410", q); end
    endtask

    task automatic test_reset_mid;
        int c; logic [31:0] q; logic m, il;
        req(0, SW, 8'd12, 32'h01020304, c, q, m, il);
        req(0, LW, 8'd0, 32'h0, c, q, m, il);
        @(negedge clk);
        opcode = SW; address = 8'd12; data_in = 32'hDEADBEEF; en = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, mfc} !== 2'b10) begin errors++;
            $display("FAIL mid_wait got busy=%b mfc=%b want 1/0", busy, mfc); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, mfc, mis_o, ill_o} !== 4'b0 || dout !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got %b d=%h want 0000/0",
                     {busy, mfc, mis_o, ill_o}, dout);
        end
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        req(0, LW, 8'd12, 32'h0, c, q, m, il);
        checks++;
        if (q !== 32'h01020304) begin errors++;
            $display("FAIL reset_nowrite got %h want 01020304", q); end
    endtask

    task automatic test_ws0;
        int c; logic [31:0] q; logic m, il;
        req(1, SW, 8'd16, 32'hCAFEF00D, c, q, m, il);
        checks++;
        if (c !== 1) begin errors++;
            $display("FAIL ws0_sw_lat got %0d want 1", c); end
        req(1, LW, 8'd16, 32'h0, c, q, m, il);
        checks++;
        if (q !== 32'hCAFEF00D || c !== 1) begin errors++;
            $display("FAIL ws0_lw got %h/%0d want cafef00d/1", q, c); end
        req(1, LSB, 8'd17, 32'h0, c, q, m, il);
        checks++;
        if (q !== 32'hFFFFFFFE) begin errors++;
            $display("FAIL ws0_lsb got %h want fffffffe", q); end
        req(1, LUHW, 8'd18, 32'h0, c, q, m, il);
        checks++;
        if (q !== 32'h0000F00D) begin errors++;
            $display("FAIL ws0_luhw got %h want 0000f00d", q); end
        req(1, LUHW, 8'd17, 32'h0, c, q, m, il);
        checks++;
        if ({m, il} !== 2'b10 || c !== 1 || q !== 32'h0000F00D) begin
            errors++;
            $display("FAIL ws0_mis got m=%b i=%b c=%0d q=%h want 1/0/1/0000f00d",
                     m, il, c, q);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        en = 1'b0; en0 = 1'b0;
        opcode = '0; address = '0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        test_word();
        test_byte();
        test_half();
        test_faults();
        test_ldstub();
        test_hold();
        test_reset_mid();
        test_ws0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl_sparc.md
# mem_ctrl_sparc

Parametrised, clocked successor to the 256x8 byte memory used behind the MAR/MDR datapath. It services the full SPARC V8 integer load/store subset (word, halfword, byte, signed/unsigned, plus LDSTUB) over a MOV/MFC handshake with programmable wait states. It checks alignment and opcode legality, and reports faults to the control unit instead of corrupting memory. Byte ordering is big-endian: the MSB is at the lowest address.

## Interface
- ADDR_WIDTH, 8: byte-address width; DEPTH = 2**ADDR_WIDTH bytes; ADDR_WIDTH >= 2.
- WAIT_STATES, 2: extra cycles between request acceptance and array access; range 0..15.

- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  MOV request; held high until mfc is seen.
- opcode  in  6  access type, sampled with the request.
- address  in  ADDR_WIDTH  byte address (MAR), sampled with the request.
- data_in  in  32  store data (MDR), sampled with the request.
- data_out  out  32  load result; reset 0.
- mfc  out  1  memory function complete; reset 0.
- busy  out  1  high in every state except IDLE; reset 0.
- misaligned  out  1  fault flag valid while mfc=1; reset 0.
- illegal_op  out  1  fault flag valid while mfc=1; reset 0.

## Operation
- Opcodes:
  - LOAD_W 000000, LOAD_UB 000001, LOAD_UHW 000010, LOAD_SB 001001, LOAD_SHW 001010.
  - STORE_W 000100, STORE_B 000101, STORE_HW 000110, LDSTUB 001101.
  - Any other value is illegal.
- FSM states are IDLE, WAIT, ACCESS and DONE.
- IDLE:
  - enable=1 at an edge latches opcode, address and data_in.
  - Illegal opcode -> DONE with illegal_op=1.
  - Word with address[1:0]!=0, or halfword with address[0]!=0 -> DONE with misaligned=1.
  - Otherwise -> WAIT, or -> ACCESS directly if WAIT_STATES=0.
- WAIT: a counter loads WAIT_STATES-1 and decrements; at 0 -> ACCESS.
- ACCESS (single edge):
  - Stores write 1, 2 or 4 bytes using the low 8, 16 or 32 bits of the latched data, big-endian.
  - Loads update data_out:
    - UB zero-extends Mem[a].
    - SB sign-extends Mem[a].
    - UHW/SHW zero- or sign-extend {Mem[a],Mem[a+1]}.
    - W returns {Mem[a..a+3]}.
  - LDSTUB: data_out = zero-extended old Mem[a], and Mem[a] <= 8'hFF on the same edge (atomic).
  - Then -> DONE.
- DONE:
  - mfc=1; fault flags hold.
  - Remains in DONE while enable=1.
  - enable=0 -> IDLE; mfc and flags clear on that edge.
- Faulted requests never write memory and never change data_out.
- Stores leave data_out unchanged.
- data_out holds its last load value indefinitely.
- The array is not reset; contents survive reset_n.

## Timing
- Request sampled at edge E0.
- Legal access:
  - Array write/read occurs at edge E0+WAIT_STATES+1.
  - mfc and data_out are valid after edge E0+WAIT_STATES+1 (registered outputs, same edge as ACCESS completes).
  - With default parameters, mfc rises 3 cycles after the request edge.
- Faulted access: mfc, misaligned or illegal_op high after E0+1.
- Minimum handshake: enable must drop for at least one edge after mfc before the next request is accepted. Back-to-back throughput is therefore one request per WAIT_STATES+3 cycles.
- Input changes while busy=1 are ignored; only the values latched at E0 are used.
- reset_n low mid-operation:
  - FSM -> IDLE and all outputs -> 0 immediately.
  - A store not yet at its ACCESS edge is dropped with no partial write.

## Structure
- Package mem_ctrl_pkg contains:
  - the opcode localparams above;
  - the state enum {IDLE, WAIT, ACCESS, DONE};
  - a function decoding opcode to size (B/HW/W), signed, is_store, is_ldstub and legal.
- Sub-module byte_ram holds DEPTH x 8 storage with one address-aligned 4-lane port:
  - 4 byte-write enables;
  - 32-bit write and read data;
  - synchronous write, combinational read.
- The controller FSM, wait counter, lane steering and extension logic live in mem_ctrl_sparc.

## Test plan
- STORE_W 234512 at 0, then LOAD_W at 0:
  - Mem[0..3] = 00,03,94,10.
  - data_out = 0x00039410.
  - mfc after 3 cycles (default parameters).
- STORE_B -5 at 4, then LOAD_UB at 4 and LOAD_SB at 4:
  - Mem[4] = FB.
  - LOAD_UB -> 0x000000FB; LOAD_SB -> 0xFFFFFFFB.
  - Mem[5..7] unchanged.
- STORE_HW -2356 at 8, then LOAD_UHW and LOAD_SHW at 8:
  - Mem[8..9] = F6,CC.
  - LOAD_UHW -> 0x0000F6CC; LOAD_SHW -> 0xFFFFF6CC.
- LOAD_W at 2 and STORE_HW at 9:
  - misaligned=1 and mfc after 1 cycle.
  - Memory and data_out unchanged.
  - Opcode 111111 -> illegal_op=1, no write.
- LDSTUB at 4 (Mem[4]=FB), then LOAD_UB at 4:
  - LDSTUB returns 0x000000FB.
  - LOAD_UB then returns 0x000000FF.
- Protocol and reset:
  - Hold enable high 5 cycles after mfc: mfc stays 1 and no second access occurs.
  - Assert reset_n low during WAIT of STORE_W 0xDEADBEEF at 12: outputs go to 0 and Mem[12..15] is unchanged.
  - Repeat with WAIT_STATES=0: mfc follows 1 cycle after the request edge.
